sub8_serial: RTL

Bit-serial two's-complement subtractor, the subtract-side counterpart of the team's 8-bit adder. It computes diff = a - b one bit per cycle, LSB first, as a + ~b + 1. It reports signed overflow, unsigned borrow and zero. It sits behind a valid/ready operand interface and drives a valid/ready result interface, for area-constrained datapaths.

---
 rtl/sub8_serial_pkg.sv | 24 ++
 rtl/sub8_serial_fa.sv | 16 +
 rtl/sub8_serial.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sub8_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - SUB8_DEF_WIDTH : default operand/result width
//   - state_e        : FSM state encoding (IDLE/RUN/DONE)
//   - clog2()        : counter width helper (never returns less than 1)
package sub8_serial_pkg;

  localparam int SUB8_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sub8_serial_fa.sv
// serial_fa_cell: combinational 1-bit full adder used by the serial datapath.
// Ports:
//   a_bit, b_bit, cin : addend bits and carry in
//   sum, cout         : sum bit and carry out
module serial_fa_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a_bit ^ b_bit ^ cin;
  assign cout = (a_bit & b_bit) | (cin & (a_bit ^ b_bit));

endmodule

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial two's-complement subtractor, diff = a - b computed
// LSB first as a + ~b + 1, one bit per clock, behind valid/ready handshakes.
// Optional build macro: SUB8_SERIAL_SATURATE_EN clamps diff on signed overflow
// to the most-positive (sign_a = 0) or most-negative (sign_a = 1) value.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a minuend, b subtrahend)
//   out_valid / out_ready: result handshake
//   diff                 : a - b modulo 2^WIDTH (or clamped, see macro)
//   overflow, borrow, zero : signed overflow, unsigned borrow, diff == 0
module sub8_serial
  import sub8_serial_pkg::*;
#(
  parameter int WIDTH = SUB8_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow,
  output logic             zero
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;      // first WIDTH-1 sum bits; final bit joins at the top
  logic             carry_q, sign_a_q, sign_b_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             ovf_q, brw_q, zero_q;

  logic fa_sum, fa_cout;

  serial_fa_cell u_fa (
    .a_bit (a_q[0]),
    .b_bit (b_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .cout  (fa_cout)
  );

  // full_d is only a complete result on the last RUN cycle, when res_q
  // already holds bits [WIDTH-2:0].
  logic [WIDTH-1:0] full_d;
  logic [WIDTH-2:0] res_d;
  logic [WIDTH-1:0] diff_d;
  logic             ovf_d;

  always_comb begin
    full_d = {fa_sum, res_q};
    res_d  = full_d[WIDTH-1:1];
    ovf_d  = (sign_a_q != sign_b_q) && (fa_sum != sign_a_q);
    diff_d = full_d;
`ifdef SUB8_SERIAL_SATURATE_EN
    if (ovf_d) diff_d = {sign_a_q, {(WIDTH-1){~sign_a_q}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      carry_q     <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      ovf_q       <= 1'b0;
      brw_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= ~b;
            sign_a_q   <= a[WIDTH-1];
            sign_b_q   <= b[WIDTH-1];
            carry_q    <= 1'b1;     // the +1 of the two's-complement negate
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= res_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            brw_q       <= ~fa_cout;
            zero_q      <= (diff_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_ready returns one cycle after the result handshake, so no
          // operand can be taken in the same cycle the result is consumed.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign overflow  = ovf_q;
  assign borrow    = brw_q;
  assign zero      = zero_q;

endmodule
